pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline register carrying one
// decoded-instruction payload (IR, PC, register numbers, operand data).
// Optional macro PIPE_STAGE_PERF_EN adds the bubble_cnt performance counter
// (downstream ready but nothing to offer), saturating at all-ones.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_EMPTY | nothing held; in_ready=1, out_valid=0
// S_ONE   | main holds the head payload; skid unused; in_ready=1
// S_TWO   | main holds the head, skid holds the next; in_ready=0
module pipe_stage_reg #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        IR_in,
  input  logic [WIDTH-3:0]        PC_in,
  input  logic [REG_ADDR_LEN-1:0] Rd_no_in,
  input  logic [REG_ADDR_LEN-1:0] Rs_no_in,
  input  logic [REG_ADDR_LEN-1:0] Rt_no_in,
  input  logic [WIDTH-1:0]        Rs_data_in,
  input  logic [WIDTH-1:0]        Rt_data_in,
  output logic [WIDTH-1:0]        IR_out,
  output logic [WIDTH-3:0]        PC_out,
  output logic [REG_ADDR_LEN-1:0] Rd_no_out,
  output logic [REG_ADDR_LEN-1:0] Rs_no_out,
  output logic [WIDTH-1:0]        Rs_data_out,
  output logic [REG_ADDR_LEN-1:0] Rt_no_out,
  output logic [WIDTH-1:0]        Rt_data_out
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]             bubble_cnt
`endif
);

  localparam int PAY_W = 3*WIDTH + (WIDTH-2) + 3*REG_ADDR_LEN;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [PAY_W-1:0] r_main;
  logic [PAY_W-1:0] r_skid;

  logic [1:0]       w_state_nxt;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_ld_in;
  logic             w_main_ld_skid;
  logic             w_skid_ld;
  logic [PAY_W-1:0] w_pay_in;

  // Each field comes straight from its own input port.
  assign w_pay_in = {IR_in, PC_in, Rd_no_in, Rs_no_in, Rs_data_in, Rt_no_in, Rt_data_in};

  assign {IR_out, PC_out, Rd_no_out, Rs_no_out, Rs_data_out, Rt_no_out, Rt_data_out} = r_main;

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Next-state and load-enable decode; flush empties without touching data.
  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            w_main_ld_in = 1'b1;
            w_state_nxt  = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_ld_in = 1'b1;
          end else if (w_in_xfer) begin
            w_skid_ld   = 1'b1;
            w_state_nxt = S_TWO;
          end else if (w_out_xfer) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_xfer) begin
            w_main_ld_skid = 1'b1;
            w_state_nxt    = S_ONE;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // State plus registered handshake outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_TWO);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  // Payload storage: main drives the outputs, skid absorbs one stalled beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_ld_in) begin
        r_main <= w_pay_in;
      end else if (w_main_ld_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_ld) begin
        r_skid <= w_pay_in;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_bubble_cnt;

  // Count cycles where downstream is ready but starved; flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (out_ready && !r_out_valid && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed table, hand sequences, and a
// randomized run against a queue-based reference model.
module tb_pipe_stage_reg;
  localparam int W  = 32;
  localparam int RA = 5;
  localparam int PW = 3*W + (W-2) + 3*RA;
  typedef logic [PW-1:0] pay_t;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, flush;
  logic in_ready, out_valid;
  logic [W-1:0]  IR_in, Rs_data_in, Rt_data_in;
  logic [W-3:0]  PC_in;
  logic [RA-1:0] Rd_no_in, Rs_no_in, Rt_no_in;
  logic [W-1:0]  IR_out, Rs_data_out, Rt_data_out;
  logic [W-3:0]  PC_out;
  logic [RA-1:0] Rd_no_out, Rs_no_out, Rt_no_out;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   bubble_cnt;
`endif

  pipe_stage_reg #(.WIDTH(W), .REG_ADDR_LEN(RA)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush),
    .IR_in(IR_in), .PC_in(PC_in), .Rd_no_in(Rd_no_in), .Rs_no_in(Rs_no_in),
    .Rt_no_in(Rt_no_in), .Rs_data_in(Rs_data_in), .Rt_data_in(Rt_data_in),
    .IR_out(IR_out), .PC_out(PC_out), .Rd_no_out(Rd_no_out), .Rs_no_out(Rs_no_out),
    .Rs_data_out(Rs_data_out), .Rt_no_out(Rt_no_out), .Rt_data_out(Rt_data_out)
`ifdef PIPE_STAGE_PERF_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a bounded FIFO of payloads plus last-shown output value.
  pay_t        q[$];
  pay_t        m_out;
  logic [31:0] m_bub;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic pay_t mkpay(input logic [31:0] ir);
    logic [31:0] t;
    t = ir;
    return {t, ~t[29:0], t[4:0], t[9:5], t * 32'd3, t[14:10], t ^ 32'hA5A5_A5A5};
  endfunction

  task automatic chk(input string nm, input pay_t act, input pay_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic ordy, input logic fl, input pay_t p);
    rst = r; in_valid = iv; out_ready = ordy; flush = fl;
    {IR_in, PC_in, Rd_no_in, Rs_no_in, Rs_data_in, Rt_no_in, Rt_data_in} = p;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    pay_t p;
    logic inx, outx;
    p = {IR_in, PC_in, Rd_no_in, Rs_no_in, Rs_data_in, Rt_no_in, Rt_data_in};
    if (rst) begin
      q.delete();
      m_out = '0;
      m_bub = '0;
    end else begin
      if (out_ready && q.size() == 0 && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
      if (flush) begin
        q.delete();
      end else begin
        inx  = in_valid && (q.size() < 2);
        outx = out_ready && (q.size() > 0);
        if (outx) void'(q.pop_front());
        if (inx) q.push_back(p);
        if (q.size() > 0) m_out = q[0];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, pay_t'(out_valid), pay_t'(q.size() > 0));
    chk({tag, ".in_ready"},  pay_t'(in_ready),  pay_t'(q.size() < 2));
    chk({tag, ".payload"},
        {IR_out, PC_out, Rd_no_out, Rs_no_out, Rs_data_out, Rt_no_out, Rt_data_out}, m_out);
`ifdef PIPE_STAGE_PERF_EN
    chk({tag, ".bubble_cnt"}, pay_t'(bubble_cnt), pay_t'(m_bub));
`endif
  endtask

  typedef struct {
    logic        r, iv, ordy, fl;
    logic [31:0] ir;
    logic        ev, erdy;
    logic [31:0] eir;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic r, input logic iv, input logic ordy, input logic fl,
                              input logic [31:0] ir, input logic ev, input logic erdy,
                              input logic [31:0] eir);
    vec_t v;
    v.r = r; v.iv = iv; v.ordy = ordy; v.fl = fl; v.ir = ir;
    v.ev = ev; v.erdy = erdy; v.eir = eir;
    return v;
  endfunction

  initial begin
    m_out = '0;
    m_bub = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);

    //            rst iv  ordy fl   ir          ov  rdy  ir_out
    tbl[0]  = mk(1, 0, 0, 0, 32'h0,     0, 1, 32'h0);
    tbl[1]  = mk(0, 1, 1, 0, 32'h1234,  1, 1, 32'h1234);
    tbl[2]  = mk(0, 0, 1, 0, 32'h0,     0, 1, 32'h1234);
    tbl[3]  = mk(0, 1, 1, 0, 32'hA,     1, 1, 32'hA);
    tbl[4]  = mk(0, 1, 1, 0, 32'hB,     1, 1, 32'hB);
    tbl[5]  = mk(0, 1, 1, 0, 32'hC,     1, 1, 32'hC);
    tbl[6]  = mk(0, 0, 0, 0, 32'h0,     1, 1, 32'hC);
    tbl[7]  = mk(0, 0, 1, 0, 32'h0,     0, 1, 32'hC);
    tbl[8]  = mk(0, 1, 0, 0, 32'h111,   1, 1, 32'h111);
    tbl[9]  = mk(0, 1, 0, 0, 32'h222,   1, 0, 32'h111);
    tbl[10] = mk(0, 1, 0, 0, 32'h999,   1, 0, 32'h111);
    tbl[11] = mk(0, 0, 1, 0, 32'h0,     1, 1, 32'h222);
    tbl[12] = mk(0, 0, 1, 0, 32'h0,     0, 1, 32'h222);
    tbl[13] = mk(0, 1, 0, 0, 32'h333,   1, 1, 32'h333);
    tbl[14] = mk(0, 1, 0, 0, 32'h444,   1, 0, 32'h333);
    tbl[15] = mk(0, 1, 1, 1, 32'h555,   0, 1, 32'h333);
    tbl[16] = mk(0, 0, 1, 0, 32'h0,     0, 1, 32'h333);
    tbl[17] = mk(0, 1, 0, 0, 32'h666,   1, 1, 32'h666);
    tbl[18] = mk(0, 1, 0, 0, 32'h777,   1, 0, 32'h666);
    tbl[19] = mk(1, 1, 1, 1, 32'h888,   0, 1, 32'h0);
    tbl[20] = mk(0, 0, 1, 0, 32'h0,     0, 1, 32'h0);

    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].r, tbl[i].iv, tbl[i].ordy, tbl[i].fl, mkpay(tbl[i].ir));
      tick();
      chk($sformatf("tbl%0d.out_valid", i), pay_t'(out_valid), pay_t'(tbl[i].ev));
      chk($sformatf("tbl%0d.in_ready", i),  pay_t'(in_ready),  pay_t'(tbl[i].erdy));
      chk($sformatf("tbl%0d.IR_out", i),    pay_t'(IR_out),    pay_t'(tbl[i].eir));
      check_model($sformatf("tbl%0d.model", i));
    end

    // Reset, then ten starved cycles, then a lone payload carrying DEADBEEF.
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
      tick();
    end
`ifdef PIPE_STAGE_PERF_EN
    chk("starve10.bubble_cnt", pay_t'(bubble_cnt), pay_t'(32'd10));
`endif
    drive(1'b0, 1'b1, 1'b0, 1'b0, {32'h0, 30'h0, 5'd0, 5'd0, 32'hDEAD_BEEF, 5'd0, 32'h0});
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("deadbeef.Rs_data_out", pay_t'(Rs_data_out), pay_t'(32'hDEAD_BEEF));
    chk("deadbeef.out_valid",   pay_t'(out_valid),   pay_t'(1'b1));
    check_model("deadbeef.model");

    // Randomized run against the FIFO model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 31) == 0),
            {$urandom(), 30'($urandom()), 5'($urandom()), 5'($urandom()),
             $urandom(), 5'($urandom()), $urandom()});
      tick();
      check_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
